// File: rtl/icache_pkg.sv
// icache_pkg: geometry (INDEX_BITS, WORD_OFS_BITS, TAG_BITS), address field positions, FSM states, word address helper
package icache_pkg;
  localparam int INDEX_BITS = 4;
  localparam int WORD_OFS_BITS = 2;
  localparam int TAG_BITS = 32 - 2 - WORD_OFS_BITS - INDEX_BITS;
  localparam int LINE_BITS = TAG_BITS + INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int OFS_LO = 2;
  localparam int IDX_LO = OFS_LO + WORD_OFS_BITS;
  localparam int TAG_LO = IDX_LO + INDEX_BITS;
  localparam logic [WORD_OFS_BITS-1:0] LAST_WORD = '1;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  function automatic logic [31:0] word_addr(input logic [LINE_BITS-1:0] line, input logic [WORD_OFS_BITS-1:0] ofs);
    return {line, ofs, 2'b00};
  endfunction
endpackage

// File: rtl/icache_direct_if.sv
// icache_direct_if: fetch bus (fetch_addr, instr_valid, instr) and fill bus (mem_req, mem_addr, mem_ack, mem_data); slave = cache, master = fetcher/memory
interface icache_direct_if;
  logic [31:0] fetch_addr;
  logic instr_valid;
  logic [31:0] instr;
  logic mem_req;
  logic [31:0] mem_addr;
  logic mem_ack;
  logic [31:0] mem_data;
  modport slave (input fetch_addr, mem_ack, mem_data, output instr_valid, instr, mem_req, mem_addr);
  modport master (output fetch_addr, mem_ack, mem_data, input instr_valid, instr, mem_req, mem_addr);
endinterface

// File: rtl/icache_data_array.sv
// icache_data_array: line data store, sync write / async read; ports clk, we, waddr, wdata, raddr, rdata
module icache_data_array #(
  parameter int AW = 6
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped I-cache; ports clk, rst (async, active-low), rdy (freeze), bus (fetch + fill), perf_hits/perf_misses when ICACHE_PERF_EN
module icache_direct
  import icache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  icache_direct_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);
  state_t state;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [LINE_BITS-1:0] line;
  logic [WORD_OFS_BITS-1:0] cnt;
  logic mem_req;
  logic [TAG_BITS-1:0] f_tag;
  logic [INDEX_BITS-1:0] f_idx;
  logic [INDEX_BITS-1:0] l_idx;
  logic [WORD_OFS_BITS-1:0] f_ofs;
  logic [31:0] rdata;
  logic hit;
  logic fill_ack;
  logic last;
  logic unused_ok;
  assign f_tag = bus.fetch_addr[31:TAG_LO];
  assign f_idx = bus.fetch_addr[TAG_LO-1:IDX_LO];
  assign f_ofs = bus.fetch_addr[IDX_LO-1:OFS_LO];
  assign unused_ok = ^bus.fetch_addr[OFS_LO-1:0];
  assign l_idx = line[INDEX_BITS-1:0];
  assign hit = valid[f_idx] && tags[f_idx] == f_tag && state == IDLE && rdy;
  assign fill_ack = state == FILL && rdy && bus.mem_ack;
  assign last = cnt == LAST_WORD;
  assign bus.instr_valid = hit;
  assign bus.instr = hit ? rdata : '0;
  assign bus.mem_req = mem_req;
  assign bus.mem_addr = word_addr(line, cnt);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      valid <= '0;
      line <= '0;
      cnt <= '0;
      mem_req <= 1'b0;
    end else if (rdy)
      case (state)
        IDLE: if (!hit) begin
          line <= bus.fetch_addr[31:IDX_LO];
          cnt <= '0;
          valid[f_idx] <= 1'b0;
          mem_req <= 1'b1;
          state <= FILL;
        end
        FILL: if (bus.mem_ack) begin
          cnt <= cnt + 1'b1;
          if (last) begin
            valid[l_idx] <= 1'b1;
            mem_req <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
  always_ff @(posedge clk)
    if (fill_ack && last) tags[l_idx] <= line[LINE_BITS-1:INDEX_BITS];
  icache_data_array #(.AW(INDEX_BITS + WORD_OFS_BITS)) u_data (
    .clk(clk),
    .we(fill_ack),
    .waddr({l_idx, cnt}),
    .wdata(bus.mem_data),
    .raddr({f_idx, f_ofs}),
    .rdata(rdata)
  );
`ifdef ICACHE_PERF_EN
  logic miss;
  assign miss = state == IDLE && rdy && !hit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      perf_hits <= '0;
      perf_misses <= '0;
    end else begin
      if (hit && !(&perf_hits)) perf_hits <= perf_hits + 1'b1;
      if (miss && !(&perf_misses)) perf_misses <= perf_misses + 1'b1;
    end
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed + random fetches against a line-level cache model and a latency-programmable memory responder
module tb_icache_direct;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  icache_direct_if bus();
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
`endif
  int n_assert = 0;
  int n_fail = 0;
  int lat = 2;
  int wcnt = 0;
  bit spur = 1'b0;
  logic [31:0] log[$];
  time ack_t = 0;
  bit m_v[16];
  logic [31:0] m_line[16];

  always #5 clk = ~clk;

  icache_direct dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hits(perf_hits),
    .perf_misses(perf_misses)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0: w = 32'h00000013;
      32'h4: w = 32'h00100093;
      32'h8: w = 32'h00200113;
      32'hC: w = 32'h00300193;
      default: w = (a * 32'h9E3779B1) ^ 32'hA5A50000;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, inout int c);
    while (!bus.instr_valid && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("valid_timeout", 32'(c < budget), 1);
  endtask

  task automatic chk_line(input string tag, input logic [31:0] base);
    chk(tag, log.size(), 4);
    if (log.size() == 4)
      for (int i = 0; i < 4; i++) chk(tag, log[i], base + 32'(4 * i));
  endtask

  task automatic fetch(input logic [31:0] a);
    int c;
    int drops;
    logic [31:0] line;
    logic [3:0] ix;
    line = a & ~32'hF;
    ix = a[7:4];
    bus.fetch_addr = a;
    #1;
    if (m_v[ix] && m_line[ix] == line) begin
      chk("hit_valid", 32'(bus.instr_valid), 1);
      chk("hit_instr", bus.instr, mem_word(a & ~32'h3));
      chk("hit_noreq", 32'(bus.mem_req), 0);
    end else begin
      chk("miss_valid", 32'(bus.instr_valid), 0);
      log.delete();
      c = 0;
      drops = 0;
      while (!bus.instr_valid && c < 200) begin
        @(negedge clk);
        #1;
        c++;
        if (log.size() < 4 && !bus.mem_req) drops++;
      end
      chk("fill_timeout", 32'(c < 200), 1);
      chk("req_held", drops, 0);
      chk_line("fill_addr", line);
      chk("hit_lat", 32'($time - ack_t), 19);
      chk("fill_instr", bus.instr, mem_word(a & ~32'h3));
      m_v[ix] = 1'b1;
      m_line[ix] = line;
    end
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      #2;
      bus.mem_ack = 1'b0;
      if (spur) begin
        bus.mem_ack = 1'b1;
        bus.mem_data = 32'hDEADBEEF;
      end else if (bus.mem_req && rdy && rst) begin
        if (wcnt >= lat) begin
          bus.mem_ack = 1'b1;
          bus.mem_data = mem_word(bus.mem_addr);
          log.push_back(bus.mem_addr);
          ack_t = $time;
          wcnt = 0;
        end else wcnt++;
      end else if (!bus.mem_req) wcnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] ma;
    logic [31:0] a;
    rst = 1'b0;
    rdy = 1'b1;
    bus.fetch_addr = '0;
    foreach (m_v[i]) m_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_iv", 32'(bus.instr_valid), 0);
    chk("rst_instr", bus.instr, 0);
    rst = 1'b1;
    fetch(32'h0);
    fetch(32'h8);
    bus.fetch_addr = 32'h8;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    chk("spur_req", 32'(bus.mem_req), 0);
    fetch(32'h0);
    fetch(32'h100);
    fetch(32'h0);
    bus.fetch_addr = 32'h40;
    log.delete();
    c = 0;
    while (log.size() < 2 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    bus.fetch_addr = 32'h80;
    wait_valid(300, c);
    chk("redir_len", log.size(), 8);
    if (log.size() == 8)
      for (int i = 0; i < 8; i++) chk("redir_addr", log[i], (i < 4 ? 32'h40 : 32'h70) + 32'(4 * i));
    chk("redir_instr", bus.instr, mem_word(32'h80));
    m_v[4] = 1'b1;
    m_line[4] = 32'h40;
    m_v[8] = 1'b1;
    m_line[8] = 32'h80;
    fetch(32'h44);
    bus.fetch_addr = 32'hC0;
    log.delete();
    c = 0;
    while (log.size() < 1 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    rdy = 1'b0;
    ma = bus.mem_addr;
    chk("stall_addr", ma, 32'hC4);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("stall_hold", bus.mem_addr, ma);
      chk("stall_req", 32'(bus.mem_req), 1);
      chk("stall_iv", 32'(bus.instr_valid), 0);
    end
    chk("stall_noack", log.size(), 1);
    rdy = 1'b1;
    c = 0;
    wait_valid(100, c);
    chk_line("stall_fill", 32'hC0);
    chk("stall_instr", bus.instr, mem_word(32'hC0));
    m_v[12] = 1'b1;
    m_line[12] = 32'hC0;
    bus.fetch_addr = 32'h300;
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("frz_req", 32'(bus.mem_req), 0);
    chk("frz_iv", 32'(bus.instr_valid), 0);
    rdy = 1'b1;
    fetch(32'h8);
    bus.fetch_addr = 32'h200;
    log.delete();
    c = 0;
    while (log.size() < 2 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(bus.mem_req), 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_iv", 32'(bus.instr_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    foreach (m_v[i]) m_v[i] = 1'b0;
    fetch(32'h0);
`ifdef ICACHE_PERF_EN
    repeat (3) @(negedge clk);
    #1;
    chk("perf_hits", perf_hits, 3);
    chk("perf_misses", perf_misses, 1);
    force dut.perf_hits = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.perf_hits;
    @(negedge clk);
    #1;
    chk("perf_sat", perf_hits, 32'hFFFFFFFF);
    chk("perf_misses2", perf_misses, 1);
`endif
    for (int k = 0; k < 40; k++) begin
      lat = int'($urandom_range(0, 3));
      a = (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 3)) << 8) |
          (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
      fetch(a);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache directly upstream of the instruction fetcher.
- Fetcher drives a fetch address (its PC). Cache returns the instruction word combinationally on a hit.
- On a miss it fills the whole line from the memory controller, one word at a time, then serves the hit.
- Read-only. There is no write or coherence path; self-modifying code is out of scope.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines).
- WORD_OFS_BITS, 2, log2 of words per line (4 words = 16 B).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- rdy  in  1  global ready; 0 freezes all state
- fetch_addr  in  32  fetch address from fetcher; bits [1:0] ignored
- instr_valid  out  1  instr is valid for fetch_addr this cycle
- instr  out  32  instruction word
- mem_req  out  1  word read request to memory controller
- mem_addr  out  32  word-aligned request address
- mem_ack  in  1  one-cycle pulse; mem_data valid in the same cycle
- mem_data  in  32  returned word

Behaviour:
- Address split, with T = 32-2-WORD_OFS_BITS-INDEX_BITS:
  - word offset = [2+WORD_OFS_BITS-1:2]
  - index = next INDEX_BITS bits
  - tag = upper T bits
- Storage:
  - valid[2^INDEX_BITS] and tag array in flops.
  - data array 2^(INDEX_BITS+WORD_OFS_BITS) x 32; flops or inferred RAM with asynchronous read.
- Reset (rst=0, asynchronous):
  - all valid bits 0, FSM=IDLE, fill counter 0
  - mem_req=0, mem_addr=0, instr_valid=0, instr=0 (combinational result of the above)
  - Data and tag arrays are not reset.
- Hit:
  - hit = valid[index] && tag[index]==tag(fetch_addr) && state==IDLE && rdy.
  - instr_valid=hit, instr=data[index][word offset]. Both are combinational, zero latency.
  - instr_valid=0 whenever state!=IDLE.
- FSM:
  - IDLE: on rdy && !hit, latch line base = {tag,index,0}, clear fill counter, clear valid[index], go to FILL.
  - FILL:
    - mem_req=1, mem_addr = line base + 4*counter.
    - mem_req/mem_addr are held stable until mem_ack.
    - On mem_ack: write mem_data to data[latched index][counter] and increment counter.
    - mem_req stays high across consecutive words; back-to-back acks are legal.
    - On ack of the last word (counter == 2^WORD_OFS_BITS-1): write tag, set valid, go to DONE.
  - DONE: one cycle with mem_req=0, then IDLE. Hit earliest 2 cycles after the final ack.
- A fill always completes once started, even if fetch_addr changes (fetcher flush/redirect). After the fill, IDLE re-evaluates the current fetch_addr; a new miss starts a new fill.
- Conflict: a miss to a valid line with the same index overwrites it; no victim handling.
- rdy=0:
  - FSM, counter and arrays hold.
  - mem_req holds its value; the memory controller is also gated by rdy, so no mem_ack arrives.
  - instr_valid=0.
- mem_ack while not in FILL is ignored.
- Counter wrap: the fill counter is WORD_OFS_BITS wide; the terminal count is detected explicitly, never by overflow.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined:
  - adds outputs perf_hits[31:0] and perf_misses[31:0], reset to 0.
  - perf_hits increments on each cycle with hit && rdy. A stalled fetcher re-presenting the same address counts again; this is intentional.
  - perf_misses increments on each IDLE->FILL transition.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package icache_pkg holds:
  - INDEX_BITS/WORD_OFS_BITS defaults and derived TAG_BITS
  - FSM state enum {IDLE, FILL, DONE}
  - address field extraction functions/localparams
- One natural sub-module, icache_data_array: 2^(INDEX_BITS+WORD_OFS_BITS)x32, synchronous write, asynchronous read. It isolates a later swap to block RAM.
- FSM and tag/valid arrays stay in icache_direct.

Test Plan:
- Cold miss at fetch_addr=0x00000000, memory ack latency 2:
  - mem_addr sequence 0x0,0x4,0x8,0xC with mem_req high throughout.
  - Data 0x00000013,0x00100093,0x00200113,0x00300193 returned.
  - instr_valid=1 with instr=0x00000013 two cycles after the last ack.
- Same-line hit: after the fill, fetch_addr=0x8 -> instr_valid=1, instr=0x00200113 in the same cycle, mem_req stays 0.
- Conflict: fetch_addr=0x100 (index 0, tag 1) -> new fill 0x100..0x10C. A following fetch_addr=0x0 misses again and refills 0x0..0xC.
- Redirect mid-fill: change fetch_addr from 0x40 to 0x80 after the 2nd ack -> fill of 0x40 line completes (4 acks), then a fill of 0x80 starts. A later fetch 0x44 hits.
- rdy and reset:
  - rdy=0 for 5 cycles mid-fill -> counter and mem_addr unchanged, instr_valid=0; fill resumes when rdy=1.
  - rst=0 mid-fill -> mem_req=0 immediately (asynchronous), and the next fetch of 0x0 misses.
- ICACHE_PERF_EN: 1 miss followed by 3 hit cycles -> perf_misses=1, perf_hits=3. A counter preloaded to 0xFFFFFFFF via force stays saturated.
